// File: rtl/cassette_overlay_pkg.sv
// Shared state encoding and default glyph/address map for the cassette status overlay.
package cassette_overlay_pkg;

  typedef enum logic [2:0] {IDLE, WL, WR, BAR, DONE} state_t;

  localparam int DEF_SEGMENTS     = 16;
  localparam int DEF_PW           = 25;
  localparam int DEF_AW           = 11;
  localparam int DEF_BAR_ADDR     = 136;
  localparam int DEF_WHEEL_L_ADDR = 331;
  localparam int DEF_WHEEL_R_ADDR = 340;
  localparam int DEF_WHEEL_FRAMES = 4;
  localparam int DEF_PEAK_HOLD    = 30;

  localparam logic [7:0] DEF_WHEEL_BASE = 8'h2A;
  localparam logic [7:0] DEF_BAR_FULL   = 8'h7F;
  localparam logic [7:0] DEF_BAR_EMPTY  = 8'hA6;

endpackage

// File: rtl/cassette_overlay_ctrl_peak_meter.sv
// Per-frame level sample and peak-hold meter with linear decay after the hold time expires.
module peak_meter #(
  parameter int PEAK_HOLD = 30
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic       i_frame,
  input  logic [7:0] tape_data,
  output logic [7:0] level,
  output logic [7:0] peak
);

  localparam int HW = $clog2(PEAK_HOLD + 1);

  logic [HW-1:0] hold;

  // Decay only runs when peak > sample, so peak - 1 never underflows.
  function automatic logic [7:0] decay(input logic [7:0] pk, input logic [7:0] smp);
    logic [7:0] dec;
    dec = pk - 8'd1;
    return (dec > smp) ? dec : smp;
  endfunction

  always_ff @(posedge i_clk) begin
    if (reset) begin
      level <= '0;
      peak  <= '0;
      hold  <= '0;
    end else if (i_frame) begin
      level <= tape_data;
      if (tape_data >= peak) begin
        peak <= tape_data;
        hold <= HW'(PEAK_HOLD);
      end else if (hold != '0) begin
        hold <= hold - HW'(1);
      end else begin
        peak <= decay(peak, tape_data);
      end
    end
  end

endmodule

// File: rtl/cassette_overlay_ctrl.sv
// Overlay refresh controller: rewrites wheel and progress-bar glyphs on every tape position
// change and hosts the peak-hold level meter.
module cassette_overlay_ctrl
  import cassette_overlay_pkg::*;
#(
  parameter int         SEGMENTS     = DEF_SEGMENTS,
  parameter int         PW           = DEF_PW,
  parameter int         AW           = DEF_AW,
  parameter int         BAR_ADDR     = DEF_BAR_ADDR,
  parameter int         WHEEL_L_ADDR = DEF_WHEEL_L_ADDR,
  parameter int         WHEEL_R_ADDR = DEF_WHEEL_R_ADDR,
  parameter logic [7:0] WHEEL_BASE   = DEF_WHEEL_BASE,
  parameter int         WHEEL_FRAMES = DEF_WHEEL_FRAMES,
  parameter logic [7:0] BAR_FULL     = DEF_BAR_FULL,
  parameter logic [7:0] BAR_EMPTY    = DEF_BAR_EMPTY,
  parameter int         PEAK_HOLD    = DEF_PEAK_HOLD
) (
  input  logic          i_clk,
  input  logic          reset,
  input  logic          i_frame,
  input  logic [PW-1:0] pos,
  input  logic [PW-1:0] max,
  input  logic [7:0]    tape_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic [7:0]    level,
  output logic [7:0]    peak
);

  localparam int SEG_LG = $clog2(SEGMENTS);
  localparam int IW     = SEG_LG + 1;
  localparam int PHW    = $clog2(WHEEL_FRAMES);

  state_t          state, state_nxt;
  logic [PW-1:0]   pos_r, pos_s, max_s;
  logic [PW:0]     thr, step, step_in;
  logic [IW-1:0]   seg_i;
  logic [PHW-1:0]  ph, ph_nxt;
  logic            pending, change, fwd, go, seg_wr, seg_full;
  logic            wr_en_d;
  logic [AW-1:0]   wr_addr_d;
  logic [7:0]      wr_data_d;

  function automatic logic [7:0] wheel_glyph(input logic [PHW-1:0] p);
    return WHEEL_BASE + 8'(p);
  endfunction

  assign change   = (pos != pos_r);
  assign fwd      = (pos > pos_r);
  assign go       = change | pending;
  assign step_in  = {1'b0, max} >> SEG_LG;
  assign seg_wr   = (state == WR) || ((state == BAR) && (seg_i != IW'(SEGMENTS)));
  assign seg_full = (max_s != '0) && ({1'b0, pos_s} >= thr);

  always_comb begin
    ph_nxt = ph;
    if (change) ph_nxt = fwd ? ph + PHW'(1) : ph - PHW'(1);
  end

  // Outputs are registered, so each state computes the write presented in the following cycle.
  always_comb begin
    state_nxt = state;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    unique case (state)
      IDLE: if (go) begin
        state_nxt = WL;
        wr_en_d   = 1'b1;
        wr_addr_d = AW'(WHEEL_L_ADDR);
        wr_data_d = wheel_glyph(ph_nxt);
      end
      WL: begin
        state_nxt = WR;
        wr_en_d   = 1'b1;
        wr_addr_d = AW'(WHEEL_R_ADDR);
        wr_data_d = wheel_glyph(ph_nxt + PHW'(WHEEL_FRAMES / 2));
      end
      WR, BAR: begin
        if (seg_wr) begin
          state_nxt = BAR;
          wr_en_d   = 1'b1;
          wr_addr_d = AW'(BAR_ADDR) + AW'(seg_i);
          wr_data_d = seg_full ? BAR_FULL : BAR_EMPTY;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= 1'b1;
      ph      <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ph      <= ph_nxt;
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      busy    <= (state_nxt != IDLE);
      if ((state == IDLE) && go) pending <= 1'b0;
      else if (change)           pending <= 1'b1;
    end
  end

  // Pass datapath: snapshot on pass start, then walk the threshold one segment at a time
  always_ff @(posedge i_clk) begin
    pos_r <= pos;
    if ((state == IDLE) && go) begin
      pos_s <= pos;
      max_s <= max;
      step  <= step_in;
      thr   <= step_in;
      seg_i <= '0;
    end else if (seg_wr) begin
      seg_i <= seg_i + IW'(1);
      thr   <= thr + step;
    end
  end

  peak_meter #(.PEAK_HOLD(PEAK_HOLD)) u_meter (
    .i_clk     (i_clk),
    .reset     (reset),
    .i_frame   (i_frame),
    .tape_data (tape_data),
    .level     (level),
    .peak      (peak)
  );

endmodule

// File: tb/tb_cassette_overlay_ctrl.sv
// Randomised and directed bench for cassette_overlay_ctrl against a pass-schedule reference model.
module tb_cassette_overlay_ctrl;

  localparam int S = 16;
  localparam int F = 4;

  logic        i_clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_frame = 1'b0;
  logic [24:0] pos = '0;
  logic [24:0] max = '0;
  logic [7:0]  tape_data = '0;
  logic        wr_en, busy;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data, level, peak;

  cassette_overlay_ctrl dut (
    .i_clk(i_clk), .reset(reset), .i_frame(i_frame), .pos(pos), .max(max),
    .tape_data(tape_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .level(level), .peak(peak)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, pass_cnt = 0, wl_cyc = -1, done_cyc = -1, chg_n = 0;
  logic [7:0] wlog [0:2047];

  // Reference model: pass is idle (-1) or at slot k (0=WL, 1=WR, 2..S+1 segments, S+2 DONE)
  int m_pos_r = 0, m_ph = 0, m_cur = -1, m_ps = 0, m_ms = 0;
  bit m_pend = 1;
  int m_lvl = 0, m_pk = 0, m_hold = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input int p, input int m, input int td, input bit fr);
    bit chg;
    int k, e_addr, e_data;
    longint thr;
    @(negedge i_clk);
    reset = r; pos = 25'(p); max = 25'(m); tape_data = 8'(td); i_frame = fr;
    @(posedge i_clk);
    #1;
    cyc++;
    if (r) begin
      m_pos_r = p; m_ph = 0; m_pend = 1; m_cur = -1;
      m_lvl = 0; m_pk = 0; m_hold = 0;
    end else begin
      chg = (p != m_pos_r);
      if (chg) m_ph = (p > m_pos_r) ? (m_ph + 1) % F : (m_ph + F - 1) % F;
      m_pos_r = p;
      if (m_cur < 0) begin
        if (chg || m_pend) begin m_cur = 0; m_ps = p; m_ms = m; m_pend = 0; end
      end else begin
        if (chg) m_pend = 1;
        m_cur = (m_cur == S + 2) ? -1 : m_cur + 1;
      end
      if (fr) begin
        m_lvl = td;
        if (td >= m_pk) begin m_pk = td; m_hold = 30; end
        else if (m_hold != 0) m_hold--;
        else m_pk = (m_pk - 1 > td) ? m_pk - 1 : td;
      end
    end
    chk("wr_en", wr_en, (m_cur >= 0 && m_cur <= S + 1));
    chk("busy", busy, (m_cur >= 0));
    chk("level", level, m_lvl);
    chk("peak", peak, m_pk);
    if (m_cur >= 0 && m_cur <= S + 1) begin
      if (m_cur == 0) begin
        e_addr = 331; e_data = 8'h2A + m_ph;
      end else if (m_cur == 1) begin
        e_addr = 340; e_data = 8'h2A + (m_ph + F / 2) % F;
      end else begin
        k = m_cur - 2;
        thr = longint'(k + 1) * longint'(m_ms >> 4);
        e_addr = 136 + k;
        e_data = (m_ms != 0 && longint'(m_ps) >= thr) ? 8'h7F : 8'hA6;
      end
      chk("wr_addr", wr_addr, e_addr);
      chk("wr_data", wr_data, e_data);
    end
    if (wr_en) begin
      wlog[wr_addr] = wr_data;
      if (wr_addr == 11'd331) begin pass_cnt++; wl_cyc = cyc; end
    end
    if (busy && !wr_en) done_cyc = cyc;
  endtask

  task automatic idle(input int n, input int p, input int m);
    for (int i = 0; i < n; i++) step(0, p, m, 0, 0);
  endtask

  int rp, rm, d;

  initial begin
    // Reset and the automatic post-reset pass
    for (int i = 0; i < 3; i++) step(1, 0, 1600, 0, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    idle(24, 0, 1600);
    chk("p1_wl", wlog[331], 8'h2A);
    chk("p1_wr", wlog[340], 8'h2C);
    for (int a = 136; a <= 151; a++) chk("p1_seg", wlog[a], 8'hA6);

    // Forward move with latency check
    chg_n = cyc;
    step(0, 250, 1600, 0, 0);
    idle(24, 250, 1600);
    chk("fwd_wl_cycle", wl_cyc, chg_n + 1);
    chk("fwd_done_cycle", done_cyc, chg_n + 19);
    chk("fwd_wl", wlog[331], 8'h2B);
    chk("fwd_wr", wlog[340], 8'h2D);
    chk("fwd_seg137", wlog[137], 8'h7F);
    chk("fwd_seg138", wlog[138], 8'hA6);

    // Rewind
    step(0, 100, 1600, 0, 0);
    idle(24, 100, 1600);
    chk("rew_wl", wlog[331], 8'h2A);
    chk("rew_wr", wlog[340], 8'h2C);
    chk("rew_seg136", wlog[136], 8'h7F);
    chk("rew_seg137", wlog[137], 8'hA6);

    // Zero length and full tape
    step(0, 500, 0, 0, 0);
    idle(24, 500, 0);
    chk("max0_seg136", wlog[136], 8'hA6);
    chk("max0_seg151", wlog[151], 8'hA6);
    step(0, 1600, 1600, 0, 0);
    idle(24, 1600, 1600);
    chk("full_seg136", wlog[136], 8'h7F);
    chk("full_seg151", wlog[151], 8'h7F);

    // Three changes during BAR collapse into one follow-up pass
    pass_cnt = 0;
    step(0, 400, 1600, 0, 0);
    idle(5, 400, 1600);
    step(0, 800, 1600, 0, 0);
    step(0, 1200, 1600, 0, 0);
    step(0, 200, 1600, 0, 0);
    idle(60, 200, 1600);
    chk("collapse_passes", pass_cnt, 2);
    chk("collapse_seg137", wlog[137], 8'h7F);
    chk("collapse_seg138", wlog[138], 8'hA6);

    // Peak hold and decay
    step(0, 200, 1600, 200, 1);
    step(0, 200, 1600, 0, 0);
    chk("pk_capture", peak, 200);
    for (int f = 1; f <= 32; f++) begin
      step(0, 200, 1600, 0, 1);
      step(0, 200, 1600, 0, 0);
      if (f == 1)  chk("lvl_after", level, 0);
      if (f == 30) chk("pk_hold_end", peak, 200);
      if (f == 31) chk("pk_decay1", peak, 199);
      if (f == 32) chk("pk_decay2", peak, 198);
    end

    // Reset during a pass
    step(0, 900, 1600, 0, 0);
    idle(6, 900, 1600);
    step(1, 900, 1600, 0, 0);
    chk("abort_wr_en", wr_en, 0);
    chk("abort_busy", busy, 0);
    pass_cnt = 0;
    idle(25, 900, 1600);
    chk("post_rst_passes", pass_cnt, 1);

    // Randomised traffic
    rp = 900; rm = 1600;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        d = int'($urandom_range(0, 3000)) - 1500;
        rp = rp + d;
        if (rp < 0) rp = 0;
        if (rp > 50000) rp = 50000;
      end
      if ($urandom_range(0, 99) == 0) rm = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40000));
      step($urandom_range(0, 299) == 0, rp, rm, int'($urandom_range(0, 255)),
           $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cassette_overlay_ctrl.md
# cassette_overlay_ctrl

Parametrised controller for the cassette status overlay. It rewrites wheel and progress-bar glyphs in the overlay character RAM and drives a peak-hold level meter. It replaces the fixed 16-segment, counter-driven updater: progress is derived from `pos`/`max` on every pass, so rewind and seek are handled. Wheels animate in both directions, and a meter peak value is added. It sits between the tape player (`pos`, `max`, `tape_data`) and the character-map RAM write port; the pixel compositor consumes `level` and `peak`.

## Interface
- `SEGMENTS`, 16: progress-bar segments; power of two, 2..64.
- `PW`, 25: width of `pos` and `max`.
- `AW`, 11: char RAM address width.
- `BAR_ADDR`, 136: char RAM address of segment 0; segments are consecutive.
- `WHEEL_L_ADDR`, 331: char RAM address of the left wheel glyph.
- `WHEEL_R_ADDR`, 340: char RAM address of the right wheel glyph.
- `WHEEL_BASE`, 8'h2A: first of `WHEEL_FRAMES` consecutive wheel glyph codes.
- `WHEEL_FRAMES`, 4: wheel animation frames; power of two.
- `BAR_FULL`, 8'h7F: glyph for a filled segment.
- `BAR_EMPTY`, 8'hA6: glyph for an empty segment.
- `PEAK_HOLD`, 30: frames the peak is held before decay starts.

Ports:
- `i_clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `i_frame`, in, 1: one-cycle pulse per video frame.
- `pos`, in, PW: tape position.
- `max`, in, PW: tape length.
- `tape_data`, in, 8: instantaneous tape amplitude.
- `wr_en`, out, 1: char RAM write strobe.
- `wr_addr`, out, AW: char RAM write address.
- `wr_data`, out, 8: char RAM write data.
- `busy`, out, 1: refresh pass in progress.
- `level`, out, 8: amplitude sampled at the last frame.
- `peak`, out, 8: peak-hold amplitude.

## Operation
- `pos_r` registers `pos` every cycle. A change is `pos != pos_r`; direction is fwd if `pos > pos_r`, else rev.
- Wheel phase `ph` (log2 `WHEEL_FRAMES` bits) updates on each change: +1 on fwd, −1 on rev, wrapping modulo `WHEEL_FRAMES`.
- Left wheel glyph is `WHEEL_BASE + ph`. Right wheel glyph is `WHEEL_BASE + ((ph + WHEEL_FRAMES/2) mod WHEEL_FRAMES)`.
- FSM states:
  - IDLE: go to WL if a change is seen or `pending` is set. On exit, snapshot `pos`/`max`, clear `pending`, set `thr = step = max_s >> log2(SEGMENTS)`, and set `i = 0`.
  - WL: write the left wheel glyph → WR.
  - WR: write the right wheel glyph → BAR.
  - BAR: write segment `i` at `BAR_ADDR + i`, then `i++` and `thr += step`. Segment `i` is `BAR_FULL` iff `max_s != 0` and `pos_s >= thr`, otherwise `BAR_EMPTY`. After `i == SEGMENTS-1`, go to DONE.
  - DONE: one idle cycle → IDLE.
- `thr` is PW+1 bits and never overflows. With `max_s == 0`, all segments are empty. With `pos_s >= max_s` and `max_s != 0`, all segments are full.
- A change during WL/WR/BAR/DONE sets `pending`. The wheel phase still updates immediately. The current pass finishes using its snapshot, then a new pass starts from IDLE. Multiple changes collapse into one pending pass.
- Reset: `pending = 1`. One full pass therefore runs after reset without any `pos` change.
- Meter, on `i_frame`:
  - `level <= tape_data`.
  - If `tape_data >= peak`: `peak <= tape_data` and `hold <= PEAK_HOLD`.
  - Else if `hold != 0`: `hold--`.
  - Else: `peak <= max(peak - 1, tape_data)`.
  - Between frames, `level` and `peak` are constant.

## Timing
- Reset values: `wr_en = 0`, `wr_addr = 0`, `wr_data = 0`, `busy = 0`, `level = 0`, `peak = 0`, `ph = 0`, state IDLE.
- Outputs are registered. A change seen in cycle N gives the WL write in N+1, WR in N+2, and segments in N+3..N+2+SEGMENTS. DONE is N+3+SEGMENTS, so the earliest next pass writes WL in N+5+SEGMENTS.
- `busy` is high from the WL cycle through DONE inclusive.
- `wr_en` is high exactly one cycle per write. There are no back-to-back duplicate addresses within a pass.
- Meter updates are visible the cycle after `i_frame`.
- Reset asserted mid-pass aborts the pass: `wr_en` is 0 on the next cycle, and the post-reset pass starts after reset deasserts.

## Structure
- Package `cassette_overlay_pkg`: FSM state enum (IDLE, WL, WR, BAR, DONE) and default glyph/address constants.
- Sub-module `peak_meter`, holding `level`, `peak` and the `hold` counter, parameterised by `PEAK_HOLD`. The FSM and wheel logic stay in the top.

## Test plan
- After reset, with `max = 1600` and `pos = 0` (SEGMENTS = 16): writes go to 331 ← 8'h2A, 340 ← 8'h2C, then 136..151 all ← 8'hA6.
- `pos` 0 → 250: `ph = 1`. Writes are 331 ← 8'h2B, 340 ← 8'h2D, 136–137 ← 8'h7F, 138–151 ← 8'hA6. WL lands on cycle N+1 and DONE on N+19.
- `pos` 250 → 100 (rewind): `ph = 0`, wheels return to 8'h2A/8'h2C, only segment 136 is full.
- `max = 0` with `pos = 500`: all segments are 8'hA6. With `pos = max = 1600`: all are 8'h7F.
- `pos` changes three times during BAR: the pass completes unchanged, then exactly one further pass uses the latest `pos`.
- `tape_data = 200` for one frame, then 0: `peak` stays 200 for 30 frames, then falls by 1 per frame. `level` reads 0 from the second frame on.
